// File: rtl/transaccion_atm.sv
// transaccion_atm: transaction stage of the automatic cashier. Loads the
//   account balance on a correct PIN, waits for one amount strobe, then
//   applies a deposit or a withdrawal and reports the outcome.
// Latency: the amount strobe at edge k gives fin and the outcome pulses after
//   edge k+1, and ESPERA after edge k+2. With no strobe, the session times out
//   TIMEOUT_CICLOS cycles after the pin_valido edge.
// Backpressure: none. The block takes single-cycle pulses. pin_valido and
//   monto_stb are dropped in any state that does not expect them.
//
// Ports:
//   clk                  single clock, rising edge
//   reset                asynchronous, active-high; clears all state and outputs
//   pin_valido           start pulse from the PIN stage; samples balance_inicial
//   balance_inicial      account balance loaded at session start
//   tipo_trans           0 = deposit, 1 = withdrawal; sampled with monto_stb
//   monto_stb            one-cycle amount-valid strobe
//   monto                amount, zero-extended to BALANCE_W
//   ocupado              high in every state except ESPERA
//   balance              current balance register
//   balance_stb          pulse: balance register changed by a transaction
//   entregar_dinero      pulse: dispense cash (withdrawal accepted)
//   fondos_insuficientes pulse: withdrawal rejected
//   error_desborde       pulse: deposit rejected on overflow
//   tiempo_agotado       pulse: session aborted by timeout
//   fin                  pulse: session finished, any outcome
module transaccion_atm #(
  parameter int BALANCE_W      = 64,
  parameter int MONTO_W        = 32,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pin_valido,
  input  logic [BALANCE_W-1:0] balance_inicial,
  input  logic                 tipo_trans,
  input  logic                 monto_stb,
  input  logic [MONTO_W-1:0]   monto,
  output logic                 ocupado,
  output logic [BALANCE_W-1:0] balance,
  output logic                 balance_stb,
  output logic                 entregar_dinero,
  output logic                 fondos_insuficientes,
  output logic                 error_desborde,
  output logic                 tiempo_agotado,
  output logic                 fin
);

  // The counter only has to reach TIMEOUT_CICLOS-1.
  localparam int CNT_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CICLOS - 1);

  localparam logic [1:0] ESPERA           = 2'd0;
  localparam logic [1:0] RECIBIENDO_MONTO = 2'd1;
  localparam logic [1:0] PROCESANDO       = 2'd2;
  localparam logic [1:0] RESULTADO        = 2'd3;

  logic [1:0]           estado;
  logic [1:0]           estado_sig;
  logic [CNT_W-1:0]     contador;
  logic [BALANCE_W-1:0] monto_r;
  logic                 tipo_r;

  logic [BALANCE_W-1:0] monto_ext;
  logic [BALANCE_W:0]   suma;
  logic [BALANCE_W-1:0] resta;
  logic                 desborde;
  logic                 sin_fondos;
  logic                 monto_cero;
  logic                 timeout_hit;

  // Zero-extend the amount. This also works when MONTO_W == BALANCE_W.
  always_comb begin
    monto_ext = '0;
    monto_ext[MONTO_W-1:0] = monto;
  end

  // Evaluate the captured request against the current balance.
  // The deposit sum is one bit wider so that the carry marks an overflow.
  always_comb begin
    suma       = {1'b0, balance} + {1'b0, monto_r};
    resta      = balance - monto_r;
    desborde   = suma[BALANCE_W];
    sin_fondos = (monto_r > balance);
    monto_cero = (monto_r == '0);
  end

  // The strobe takes priority over the timeout on the same cycle.
  assign timeout_hit = (estado == RECIBIENDO_MONTO) && !monto_stb &&
                       (contador == CNT_MAX);

  always_comb begin
    estado_sig = estado;
    case (estado)
      ESPERA: begin
        if (pin_valido) estado_sig = RECIBIENDO_MONTO;
      end
      RECIBIENDO_MONTO: begin
        if (monto_stb)        estado_sig = PROCESANDO;
        else if (timeout_hit) estado_sig = RESULTADO;
      end
      PROCESANDO: estado_sig = RESULTADO;
      RESULTADO:  estado_sig = ESPERA;
      default:    estado_sig = ESPERA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado               <= ESPERA;
      contador             <= '0;
      monto_r              <= '0;
      tipo_r               <= 1'b0;
      ocupado              <= 1'b0;
      balance              <= '0;
      balance_stb          <= 1'b0;
      entregar_dinero      <= 1'b0;
      fondos_insuficientes <= 1'b0;
      error_desborde       <= 1'b0;
      tiempo_agotado       <= 1'b0;
      fin                  <= 1'b0;
    end else begin
      estado  <= estado_sig;
      // Registered version of "not in ESPERA", aligned with the state register.
      ocupado <= (estado_sig != ESPERA);

      // By default every pulse lasts one cycle.
      balance_stb          <= 1'b0;
      entregar_dinero      <= 1'b0;
      fondos_insuficientes <= 1'b0;
      error_desborde       <= 1'b0;
      tiempo_agotado       <= 1'b0;
      fin                  <= 1'b0;

      case (estado)
        ESPERA: begin
          if (pin_valido) begin
            balance  <= balance_inicial;
            contador <= '0;
          end
        end

        RECIBIENDO_MONTO: begin
          if (monto_stb) begin
            monto_r <= monto_ext;
            tipo_r  <= tipo_trans;
          end else if (timeout_hit) begin
            tiempo_agotado <= 1'b1;
            fin            <= 1'b1;
          end else begin
            contador <= contador + CNT_W'(1);
          end
        end

        PROCESANDO: begin
          fin <= 1'b1;
          if (!tipo_r) begin
            // Deposit. A zero amount leaves the balance as it is and sends no strobe.
            if (desborde) begin
              error_desborde <= 1'b1;
            end else if (!monto_cero) begin
              balance     <= suma[BALANCE_W-1:0];
              balance_stb <= 1'b1;
            end
          end else begin
            // Withdrawal. A zero amount is accepted but dispenses nothing.
            if (sin_fondos) begin
              fondos_insuficientes <= 1'b1;
            end else if (!monto_cero) begin
              balance         <= resta;
              balance_stb     <= 1'b1;
              entregar_dinero <= 1'b1;
            end
          end
        end

        RESULTADO: begin
          // The pulses clear through the defaults. The balance holds until the next session.
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transaccion_atm.sv
module tb_transaccion_atm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pin_valido = 1'b0;
  logic [63:0] balance_inicial = '0;
  logic        tipo_trans = 1'b0;
  logic        monto_stb = 1'b0;
  logic [31:0] monto = '0;
  logic        ocupado;
  logic [63:0] balance;
  logic        balance_stb;
  logic        entregar_dinero;
  logic        fondos_insuficientes;
  logic        error_desborde;
  logic        tiempo_agotado;
  logic        fin;

  int checks = 0;
  int failures = 0;

  transaccion_atm #(
    .BALANCE_W      (64),
    .MONTO_W        (32),
    .TIMEOUT_CICLOS (8)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .pin_valido           (pin_valido),
    .balance_inicial      (balance_inicial),
    .tipo_trans           (tipo_trans),
    .monto_stb            (monto_stb),
    .monto                (monto),
    .ocupado              (ocupado),
    .balance              (balance),
    .balance_stb          (balance_stb),
    .entregar_dinero      (entregar_dinero),
    .fondos_insuficientes (fondos_insuficientes),
    .error_desborde       (error_desborde),
    .tiempo_agotado       (tiempo_agotado),
    .fin                  (fin)
  );

  always #5 clk = ~clk;

  // Flag order: {ocupado, balance_stb, entregar, fondos, desborde, tiempo, fin}
  function automatic logic [6:0] flags();
    return {ocupado, balance_stb, entregar_dinero, fondos_insuficientes,
            error_desborde, tiempo_agotado, fin};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [63:0] bal);
    pin_valido = 1'b1;
    balance_inicial = bal;
    tick();
    pin_valido = 1'b0;
    check("start_ocupado", {63'd0, ocupado}, 64'd1);
    check("start_balance", balance, bal);
  endtask

  // Apply one amount and check the result cycle and the return to ESPERA.
  task automatic amount(input string tag, input logic tipo, input logic [31:0] m,
                        input logic [6:0] exp_flags, input logic [63:0] exp_bal);
    monto_stb = 1'b1;
    tipo_trans = tipo;
    monto = m;
    tick();
    monto_stb = 1'b0;
    check({tag, "_proc_flags"}, {57'd0, flags()}, {57'd0, 7'b1000000});
    tick();
    check({tag, "_res_flags"}, {57'd0, flags()}, {57'd0, exp_flags});
    check({tag, "_res_balance"}, balance, exp_bal);
    tick();
    check({tag, "_idle_flags"}, {57'd0, flags()}, 64'd0);
    check({tag, "_idle_balance"}, balance, exp_bal);
  endtask

  initial begin
    #12;
    check("reset_flags", {57'd0, flags()}, 64'd0);
    check("reset_balance", balance, 64'd0);
    reset = 1'b0;
    tick();

    // Deposit.
    start(64'd1000);
    amount("deposit", 1'b0, 32'd250, 7'b1100001, 64'd1250);

    // Exact withdrawal, then a withdrawal with insufficient funds.
    start(64'd1000);
    amount("withdraw_exact", 1'b1, 32'd1000, 7'b1110001, 64'd0);
    start(64'd500);
    amount("withdraw_insuf", 1'b1, 32'd501, 7'b1001001, 64'd500);

    // Overflow, then a zero deposit.
    start(64'hFFFF_FFFF_FFFF_FFF6);
    amount("overflow", 1'b0, 32'd10, 7'b1000101, 64'hFFFF_FFFF_FFFF_FFF6);
    start(64'd77);
    amount("deposit_zero", 1'b0, 32'd0, 7'b1000001, 64'd77);

    // Timeout: no strobe. The abort must appear exactly 8 cycles after the pin edge.
    start(64'd300);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("timeout_wait", {57'd0, flags()}, {57'd0, 7'b1000000});
    end
    tick();
    check("timeout_flags", {57'd0, flags()}, {57'd0, 7'b1000011});
    check("timeout_balance", balance, 64'd300);
    tick();
    check("timeout_idle", {57'd0, flags()}, 64'd0);

    // A strobe on the 8th cycle beats the timeout.
    start(64'd300);
    for (int i = 1; i < 8; i++) tick();
    amount("strobe_at_limit", 1'b1, 32'd100, 7'b1110001, 64'd200);

    // A monto_stb in ESPERA is ignored.
    monto_stb = 1'b1;
    tipo_trans = 1'b1;
    monto = 32'd50;
    tick();
    monto_stb = 1'b0;
    check("idle_stb_flags", {57'd0, flags()}, 64'd0);
    check("idle_stb_balance", balance, 64'd200);
    tick();
    check("idle_stb_flags2", {57'd0, flags()}, 64'd0);

    // A pin_valido in RECIBIENDO_MONTO and in PROCESANDO is ignored.
    start(64'd400);
    pin_valido = 1'b1;
    balance_inicial = 64'd9;
    tick();
    check("pin_in_recv_balance", balance, 64'd400);
    check("pin_in_recv_flags", {57'd0, flags()}, {57'd0, 7'b1000000});
    monto_stb = 1'b1;
    tipo_trans = 1'b0;
    monto = 32'd5;
    tick();
    monto_stb = 1'b0;
    tick();
    check("pin_in_proc_flags", {57'd0, flags()}, {57'd0, 7'b1100001});
    check("pin_in_proc_balance", balance, 64'd405);
    pin_valido = 1'b0;
    tick();
    check("pin_ignored_idle", {57'd0, flags()}, 64'd0);

    // An asynchronous reset in PROCESANDO.
    start(64'd600);
    monto_stb = 1'b1;
    tipo_trans = 1'b0;
    monto = 32'd1;
    tick();
    monto_stb = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("reset_mid_flags", {57'd0, flags()}, 64'd0);
    check("reset_mid_balance", balance, 64'd0);
    tick();
    check("reset_held_flags", {57'd0, flags()}, 64'd0);
    reset = 1'b0;
    tick();
    check("post_reset_idle", {57'd0, flags()}, 64'd0);
    start(64'd50);
    amount("post_reset", 1'b1, 32'd20, 7'b1110001, 64'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
